cv1k_eeprom_responder: RTL



---
 rtl/cv1k_eeprom_pkg.sv | 42 ++++
 rtl/cv1k_sync_edge.sv | 36 +++
 rtl/cv1k_eeprom_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv1k_eeprom_pkg.sv
// Shared definitions for the CV1000 serial EEPROM responder.
// Contents: 93C46-style opcodes, extended-op sub-codes (address MSBs),
// FSM state encoding, pending-program kinds, default power-up word and a
// helper that sizes the busy window for whole-array programs.
package cv1k_eeprom_pkg;

  // Two opcode bits following the start bit.
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpErase = 2'b11;
  localparam logic [1:0] OpExt   = 2'b00;

  // Extended ops are selected by the two address MSBs.
  localparam logic [1:0] SubEwen = 2'b11;
  localparam logic [1:0] SubEwds = 2'b00;
  localparam logic [1:0] SubEral = 2'b10;
  localparam logic [1:0] SubWral = 2'b01;

  localparam logic [15:0] InitWordDefault = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StCmd,
    StRead,
    StWdata,
    StWaitCe,
    StBusy
  } state_e;

  typedef enum logic [1:0] {
    PendNone,
    PendWord,
    PendAll
  } pend_e;

  // Whole-array programs need at least one clock per word.
  function automatic int unsigned busy_len(int unsigned cycles, int unsigned depth);
    return (cycles > depth) ? cycles : depth;
  endfunction

endpackage

// File: rtl/cv1k_sync_edge.sv
// Two-flop synchroniser with edge pulses.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-low reset
//   din    - asynchronous input
//   level  - synchronised level
//   rise   - one-clock pulse when level goes 0 -> 1
//   fall   - one-clock pulse when level goes 1 -> 0
module cv1k_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/cv1k_eeprom_responder.sv
// Behavioural responder for the CV1000 serial EEPROM port (93C46, x16).
// Decodes bit-banged CE/SK/DI, answers on DO, and models program busy time.
// Ports:
//   clock        - system clock
//   reset        - synchronous active-low reset (memory contents kept)
//   eeprom_ce    - chip enable, active high (async)
//   eeprom_clock - serial clock SK (async)
//   eeprom_di    - serial data in (async)
//   eeprom_do    - serial data out / ready-busy status
//   busy         - program cycle in progress
module cv1k_eeprom_responder
  import cv1k_eeprom_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 6,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned WRITE_CYCLES = 1000,
  parameter logic [DATA_BITS-1:0] INIT_WORD = DATA_BITS'(InitWordDefault)
) (
  input  logic clock,
  input  logic reset,
  input  logic eeprom_ce,
  input  logic eeprom_clock,
  input  logic eeprom_di,
  output logic eeprom_do,
  output logic busy
);

  localparam int unsigned Depth    = 2 ** ADDR_BITS;
  localparam int unsigned CmdW     = ADDR_BITS + 2;
  localparam int unsigned AllLen   = busy_len(WRITE_CYCLES, Depth);
  // Whole-array commit walks the array in the last Depth clocks of BUSY.
  localparam int unsigned AllStart = AllLen - Depth;
  localparam int unsigned CntW     = $clog2(AllLen + 1);
  localparam int unsigned BitW     = $clog2((CmdW > DATA_BITS) ? CmdW : DATA_BITS);
  localparam int unsigned DbW      = $clog2(DATA_BITS);

  // Synchronised serial inputs.
  logic sk_rise, unused_sk_level, unused_sk_fall;
  logic ce_level, ce_fall, unused_ce_rise;
  logic di_level, unused_di_rise, unused_di_fall;

  cv1k_sync_edge u_sync_sk (
    .clock (clock),
    .reset (reset),
    .din   (eeprom_clock),
    .level (unused_sk_level),
    .rise  (sk_rise),
    .fall  (unused_sk_fall)
  );

  cv1k_sync_edge u_sync_ce (
    .clock (clock),
    .reset (reset),
    .din   (eeprom_ce),
    .level (ce_level),
    .rise  (unused_ce_rise),
    .fall  (ce_fall)
  );

  cv1k_sync_edge u_sync_di (
    .clock (clock),
    .reset (reset),
    .din   (eeprom_di),
    .level (di_level),
    .rise  (unused_di_rise),
    .fall  (unused_di_fall)
  );

  // Storage. Power-up contents only; reset leaves it alone.
  logic [DATA_BITS-1:0] mem_q [Depth] = '{default: INIT_WORD};
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;

  always_ff @(posedge clock) begin
    // Gated by reset so a reset landing on the commit clock writes nothing.
    if (reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  state_e               state_q, state_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CmdW-2:0]      cmd_sr_q, cmd_sr_d;
  logic [DATA_BITS-2:0] data_sr_q, data_sr_d;
  logic                 wral_q, wral_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] rd_word_q, rd_word_d;
  logic [DbW-1:0]       rd_bit_q, rd_bit_d;
  pend_e                pend_q, pend_d;
  logic [ADDR_BITS-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_BITS-1:0] pend_data_q, pend_data_d;
  logic                 wr_en_q, wr_en_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 do_q, do_d;
  logic                 busy_q, busy_d;

  logic [CmdW-1:0]      cmd_next;
  logic [1:0]           opc;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [1:0]           sub;
  logic [DATA_BITS-1:0] data_next;
  logic [ADDR_BITS-1:0] addr_inc;
  logic [CntW-1:0]      busy_last;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    data_sr_d   = data_sr_q;
    wral_d      = wral_q;
    addr_d      = addr_q;
    rd_word_d   = rd_word_q;
    rd_bit_d    = rd_bit_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wr_en_d     = wr_en_q;
    cnt_d       = cnt_q;
    do_d        = do_q;
    busy_d      = busy_q;
    mem_we      = 1'b0;
    mem_waddr   = pend_addr_q;
    mem_wdata   = pend_data_q;

    cmd_next  = {cmd_sr_q, di_level};
    opc       = cmd_next[CmdW-1 -: 2];
    cmd_addr  = cmd_next[ADDR_BITS-1:0];
    sub       = cmd_addr[ADDR_BITS-1 -: 2];
    data_next = {data_sr_q, di_level};
    addr_inc  = addr_q + ADDR_BITS'(1);
    busy_last = (pend_q == PendAll) ? CntW'(AllLen - 1) : CntW'(WRITE_CYCLES - 1);

    // CE fall during a transfer aborts it; it also beats a same-cycle SK rise.
    if (ce_fall && (state_q inside {StStart, StCmd, StRead, StWdata})) begin
      state_d = StIdle;
      pend_d  = PendNone;
      do_d    = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          do_d = 1'b1;
          if (ce_level) begin
            state_d = StStart;
          end
        end

        StStart: begin
          if (sk_rise && di_level) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
            pend_d    = PendNone;
          end
        end

        StCmd: begin
          if (sk_rise) begin
            cmd_sr_d  = cmd_next[CmdW-2:0];
            bit_cnt_d = bit_cnt_q + BitW'(1);
            if (bit_cnt_q == BitW'(CmdW - 1)) begin
              addr_d      = cmd_addr;
              pend_addr_d = cmd_addr;
              bit_cnt_d   = '0;
              case (opc)
                OpRead: begin
                  state_d   = StRead;
                  do_d      = 1'b0;  // dummy bit
                  rd_word_d = mem_q[cmd_addr];
                  rd_bit_d  = DbW'(DATA_BITS - 1);
                end
                OpWrite: begin
                  state_d = StWdata;
                  wral_d  = 1'b0;
                end
                OpErase: begin
                  state_d     = StWaitCe;
                  pend_d      = PendWord;
                  pend_data_d = '1;
                end
                default: begin
                  case (sub)
                    SubEwen: begin
                      wr_en_d = 1'b1;
                      state_d = StWaitCe;
                    end
                    SubEwds: begin
                      wr_en_d = 1'b0;
                      state_d = StWaitCe;
                    end
                    SubEral: begin
                      state_d     = StWaitCe;
                      pend_d      = PendAll;
                      pend_data_d = '1;
                    end
                    default: begin
                      state_d = StWdata;
                      wral_d  = 1'b1;
                    end
                  endcase
                end
              endcase
            end
          end
        end

        StRead: begin
          if (sk_rise) begin
            do_d = rd_word_q[rd_bit_q];
            if (rd_bit_q == '0) begin
              // Sequential read rolls into the next word, wrapping at the top.
              addr_d    = addr_inc;
              rd_word_d = mem_q[addr_inc];
              rd_bit_d  = DbW'(DATA_BITS - 1);
            end else begin
              rd_bit_d = rd_bit_q - DbW'(1);
            end
          end
        end

        StWdata: begin
          if (sk_rise) begin
            data_sr_d = data_next[DATA_BITS-2:0];
            bit_cnt_d = bit_cnt_q + BitW'(1);
            if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
              state_d     = StWaitCe;
              pend_data_d = data_next;
              pend_d      = wral_q ? PendAll : PendWord;
            end
          end
        end

        StWaitCe: begin
          if (ce_fall) begin
            if ((pend_q != PendNone) && wr_en_q) begin
              state_d = StBusy;
              busy_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StIdle;
              pend_d  = PendNone;
            end
          end
        end

        StBusy: begin
          do_d  = ~ce_level;
          cnt_d = cnt_q + CntW'(1);
          if (pend_q == PendAll) begin
            if (cnt_q >= CntW'(AllStart)) begin
              mem_we    = 1'b1;
              mem_waddr = ADDR_BITS'(cnt_q - CntW'(AllStart));
            end
          end else if (cnt_q == busy_last) begin
            mem_we = 1'b1;
          end
          if (cnt_q == busy_last) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            pend_d  = PendNone;
            do_d    = 1'b1;
          end
        end

        default: begin
          state_d = StIdle;
          do_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      data_sr_q   <= '0;
      wral_q      <= 1'b0;
      addr_q      <= '0;
      rd_word_q   <= '0;
      rd_bit_q    <= '0;
      pend_q      <= PendNone;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      wr_en_q     <= 1'b0;
      cnt_q       <= '0;
      do_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      data_sr_q   <= data_sr_d;
      wral_q      <= wral_d;
      addr_q      <= addr_d;
      rd_word_q   <= rd_word_d;
      rd_bit_q    <= rd_bit_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      wr_en_q     <= wr_en_d;
      cnt_q       <= cnt_d;
      do_q        <= do_d;
      busy_q      <= busy_d;
    end
  end

  assign eeprom_do = do_q;
  assign busy      = busy_q;

endmodule
